// File: rtl/display_pkg.sv
// display_pkg: register map, reset constants and the 7-segment glyph table
// shared by the display_mux_n block.
package display_pkg;

  localparam logic [3:0] ADDR_DP      = 4'hC;
  localparam logic [3:0] ADDR_MODE    = 4'hD;
  localparam logic [3:0] ADDR_BLINK   = 4'hE;
  localparam logic [3:0] ADDR_BRIGHT  = 4'hF;

  // Active-low segment vector with every segment dark.
  localparam logic [6:0] SEG_BLANK    = 7'h7F;
  localparam logic [7:0] BUF_RESET    = 8'h10;
  localparam logic [3:0] BRIGHT_RESET = 4'hF;

  // Returns active-low segments (bit0 = a/top, clockwise, bit6 = g/middle).
  // The case arms list lit segments, inverted once on return.
  function automatic logic [6:0] seg_pattern(input logic [4:0] code);
    logic [6:0] lit;
    case (code)
      5'h00: lit = 7'h3F;  5'h01: lit = 7'h06;  5'h02: lit = 7'h5B;
      5'h03: lit = 7'h4F;  5'h04: lit = 7'h66;  5'h05: lit = 7'h6D;
      5'h06: lit = 7'h7D;  5'h07: lit = 7'h07;  5'h08: lit = 7'h7F;
      5'h09: lit = 7'h6F;  5'h0A: lit = 7'h77;  5'h0B: lit = 7'h7C;
      5'h0C: lit = 7'h39;  5'h0D: lit = 7'h5E;  5'h0E: lit = 7'h79;
      5'h0F: lit = 7'h71;
      5'h11: lit = 7'h40;  // '-'
      5'h12: lit = 7'h1E;  // J
      5'h13: lit = 7'h38;  // L
      5'h14: lit = 7'h73;  // P
      5'h15: lit = 7'h6D;  // S
      5'h16: lit = 7'h3E;  // U
      5'h17: lit = 7'h58;  // c
      5'h18: lit = 7'h63;  // degree
      5'h19: lit = 7'h08;  // underscore
      5'h1A: lit = 7'h01;  // overline
      5'h1B: lit = 7'h48;  // '='
      5'h1C: lit = 7'h5C;  // o
      default: lit = 7'h00; // 0x10 and 0x1D-0x1F are blank
    endcase
    return ~lit;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// display_scan_timer: per-slot counter and digit index for the display scan,
// plus the PWM/dead-time anode enable derived from the slot count.
module display_scan_timer
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       bright_i,
  output logic [IDX_W-1:0] digit_o,
  output logic             slot_start_o,
  output logic             pwm_en_o
);

  logic [SCAN_DIV-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]    digit_q, digit_d;

  // Slot counter free-runs; digit index steps on slot wrap.
  always_comb begin
    slot_d  = slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_q == '1)
      digit_d = (digit_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      digit_q <= '0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o      = digit_q;
  assign slot_start_o = (slot_q == '0);
  // Count 0 is the dead-time clock; top 4 bits vs brightness sets duty.
  assign pwm_en_o     = !slot_start_o && (slot_q[SCAN_DIV-1 -: 4] <= bright_i);

endmodule

// File: rtl/display_mux_n.sv
// display_mux_n: register-programmed N-digit common-anode 7-segment scanner
// with pattern/raw mode, dp mask, PWM brightness and dead time.
// Optional blink support is compiled in with DISPLAY_MUX_BLINK_EN.
module display_mux_n
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16,
  parameter int BLINK_DIV  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [7:0]            wr_data,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [7:0]            buf_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_mask_q, mode_mask_q;
  logic [3:0]            bright_q;
  logic [IDX_W-1:0]      digit;
  logic                  slot_start, pwm_en, blink_off;
  logic [7:0]            cur;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_d, dp_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic                  unused_ok;

  display_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .NUM_DIGITS(NUM_DIGITS),
    .IDX_W     (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .bright_i    (bright_q),
    .digit_o     (digit),
    .slot_start_o(slot_start),
    .pwm_en_o    (pwm_en)
  );

  // Write port: digit buffers and control masks, whole-byte updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= BUF_RESET;
      dp_mask_q   <= '0;
      mode_mask_q <= '0;
      bright_q    <= BRIGHT_RESET;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_addr == 4'(i)) buf_q[i] <= wr_data;
      case (wr_addr)
        ADDR_DP:     dp_mask_q   <= wr_data[NUM_DIGITS-1:0];
        ADDR_MODE:   mode_mask_q <= wr_data[NUM_DIGITS-1:0];
        ADDR_BRIGHT: bright_q    <= wr_data[3:0];
        default: ;
      endcase
    end
  end

`ifdef DISPLAY_MUX_BLINK_EN
  logic [BLINK_DIV-1:0]  blink_cnt_q;
  logic [NUM_DIGITS-1:0] blink_mask_q;

  // Free-running blink timebase and blink mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q  <= '0;
      blink_mask_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (wr_en && wr_addr == ADDR_BLINK) blink_mask_q <= wr_data[NUM_DIGITS-1:0];
    end
  end

  assign blink_off = blink_cnt_q[BLINK_DIV-1] & blink_mask_q[digit];
`else
  assign blink_off = 1'b0;
`endif

  // Decode the active digit into next segment/dp/anode values.
  always_comb begin
    cur   = buf_q[digit];
    seg_d = mode_mask_q[digit] ? ~cur[6:0] : seg_pattern(cur[4:0]);
    dp_d  = ~dp_mask_q[digit];
    if (blink_off) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
    // Digit 0 sits on the MSB of an.
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (pwm_en && digit == IDX_W'(NUM_DIGITS - 1 - i)) an_d[i] = 1'b0;
  end

  // Registered outputs so pins only move on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

  // Bit 7 of a buffer has no meaning in either mode; slot_start is spare.
  assign unused_ok = ^{cur[7], slot_start};

endmodule

// File: doc/display_mux_n.md
# display_mux_n

Parametrised, register-programmed multiplexer for NUM_DIGITS common-anode 7-segment digits with decimal points. It holds its own digit buffers, written through a simple bus write port from the CPU peripheral decoder. It scans digits at a programmable rate and adds per-digit pattern/raw mode, per-digit blink, global PWM brightness and anti-ghosting dead time. It replaces the fixed 4-digit display driver at the top of the board design.

## Interface
- NUM_DIGITS, 4: digits driven; legal range 2..8, need not be a power of 2.
- SCAN_DIV, 16: the slot counter is SCAN_DIV bits wide; each digit slot lasts 2^SCAN_DIV clocks; minimum 5.
- BLINK_DIV, 24: the blink counter is BLINK_DIV bits wide; blink period is 2^BLINK_DIV clocks.
- clk  in  1  system clock; one clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe, one cycle per write.
- wr_addr  in  4  register address.
- wr_data  in  8  write data.
- seg  out  7  segments, active-low; bit 0 = top segment, clockwise, bit 6 = middle.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit select, active-low; an[NUM_DIGITS-1] = digit 0 (leftmost).

## Operation
- Register map (write-only):
  - 0x0..NUM_DIGITS-1: digit buffer.
  - 0xC: dp mask.
  - 0xD: mode mask (1 = raw, 0 = pattern).
  - 0xE: blink mask.
  - 0xF: brightness, bits [3:0].
  - Other addresses: writes ignored. Mask bit i applies to digit i.
- Reset values:
  - Buffers 0x10 (blank); dp, mode and blink masks 0x00; brightness 0xF.
  - Slot counter, digit index and blink counter 0.
  - seg = 7'h7F, dp = 1, an = all ones.
- Pattern mode: buffer bits [4:0] index a 32-entry table.
  - 0x00-0x0F: hex digits 0-F.
  - 0x10: blank.
  - 0x11-0x17: '-', J, L, P, S, U, c.
  - 0x18-0x1C: special glyphs.
  - 0x1D-0x1F: blank.
  - Bits [7:5] are ignored.
- Raw mode: seg = ~buf[6:0]; bit 7 is ignored.
- Scan:
  - The slot counter increments every clock.
  - On wrap, the digit index advances; NUM_DIGITS-1 wraps to 0.
- Digit enable: the active digit's anode is driven only when both hold:
  - Slot counter is not 0 (one-clock dead time at the start of each slot).
  - Slot counter[SCAN_DIV-1:SCAN_DIV-4] <= brightness.
  - Consequences: brightness 0xF gives full on-time; 0x0 gives 1/16 on-time.
  - When the anode is not driven, an is all ones.
- Blink: when blink counter MSB = 1 and the active digit's blink bit = 1, force seg = 7'h7F and dp = 1. an behaves normally.

## Timing
- seg, dp and an are registered and change only on posedge clk.
- Write latency:
  - A write at edge k updates the register at edge k.
  - Output reflects it at edge k+1 if that digit is active.
- A write to the currently displayed digit produces no intermediate or mixed value.
- Brightness change takes effect from the next clock; no slot restart.
- Reset asserted mid-scan:
  - Outputs go to reset values immediately (asynchronously).
  - After release the scan resumes at digit 0, slot count 0. First anode assertion occurs at clock 2 after release.
- A write coincident with slot wrap is captured normally.

## Configuration
- DISPLAY_MUX_BLINK_EN defined: blink counter, blink mask register and blink forcing are present.
- Not defined:
  - No blink counter or blink register.
  - Writes to 0xE are ignored.
  - Digits never blink; all other behaviour is identical.

## Structure
- Package display_pkg holds:
  - Register address constants (ADDR_DP, ADDR_MODE, ADDR_BLINK, ADDR_BRIGHT).
  - SEG_BLANK constant.
  - The 32-entry pattern table as a constant function seg_pattern(code[4:0]).
- Sub-module display_scan_timer (SCAN_DIV, NUM_DIGITS) contains:
  - Slot counter and digit index.
  - Outputs: digit index, slot_start, PWM enable.

## Test plan
- Reset, then write 0x0=0x03, 0x1=0x0A, 0x2=0x10, 0x3=0x1F with SCAN_DIV=5:
  - Digit 0 shows seg=0110000, an=0111.
  - Digit 1 shows seg=0001000, an=1011.
  - Digits 2 and 3 show seg=1111111.
  - Each digit is held 32 clocks with a 1-clock all-off gap.
- Write 0xD=0x01, 0x0=0x49: digit 0 raw, seg=0110110. Write 0xC=0x02: dp=0 only during digit 1.
- Write 0xF=0x3: anode low exactly 7 clocks per 32-clock slot (counts 1..7, SCAN_DIV=5). 0xF=0x0: low on count 1 only.
- NUM_DIGITS=5: index sequence 0,1,2,3,4,0; an for digit 4 = 11110. Write to 0x5: no effect.
- With DISPLAY_MUX_BLINK_EN, BLINK_DIV=8, 0xE=0x01:
  - Digit 0 blanks for 128 of every 256 clocks; other digits are unaffected.
  - Without the macro, digit 0 never blanks.
- Assert rst_n low mid-slot:
  - seg=7F, an all ones immediately; a write attempted during reset is lost.
  - After release, digit 0 shows blank (0x10).
